// File: rtl/Cipher_defs.sv
// Shared AES definitions: byte/word/state types, S-box tables, round constants
// and the GF(2^8) helpers used by the inverse cipher and its key-schedule step.
package Cipher_defs;

  typedef logic [7:0] t_byte;
  typedef t_byte [0:3] t_word;   // word[r] = byte r of a column
  typedef t_word [0:3] t_state;  // state[c][r] = byte r+4c

  typedef enum logic [2:0] {IDLE, KEYEXP, INIT, ROUND, FINAL, DONE} t_fsm;

  localparam t_byte SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam t_byte INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  // Indexed directly by the 4-bit round counter; entries outside 1..10 are unused.
  localparam t_byte RCON [16] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  function automatic t_byte xtime(t_byte b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic t_byte gmul(t_byte a, t_byte b);
    t_byte p;
    t_byte aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  function automatic t_word rot_word(t_word w);
    return {w[1], w[2], w[3], w[0]};
  endfunction

  function automatic t_word sub_word(t_word w);
    t_word o;
    for (int i = 0; i < 4; i++) o[i] = SBOX[w[i]];
    return o;
  endfunction

  // Row r rotates right by r columns.
  function automatic t_state inv_shift_rows(t_state s);
    t_state o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[c][r] = s[(c + 4 - r) % 4][r];
    return o;
  endfunction

  function automatic t_state inv_sub_bytes(t_state s);
    t_state o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[c][r] = INV_SBOX[s[c][r]];
    return o;
  endfunction

  function automatic t_state inv_mix_columns(t_state s);
    t_state o;
    for (int c = 0; c < 4; c++) begin
      o[c][0] = gmul(s[c][0], 8'h0e) ^ gmul(s[c][1], 8'h0b) ^ gmul(s[c][2], 8'h0d) ^ gmul(s[c][3], 8'h09);
      o[c][1] = gmul(s[c][0], 8'h09) ^ gmul(s[c][1], 8'h0e) ^ gmul(s[c][2], 8'h0b) ^ gmul(s[c][3], 8'h0d);
      o[c][2] = gmul(s[c][0], 8'h0d) ^ gmul(s[c][1], 8'h09) ^ gmul(s[c][2], 8'h0e) ^ gmul(s[c][3], 8'h0b);
      o[c][3] = gmul(s[c][0], 8'h0b) ^ gmul(s[c][1], 8'h0d) ^ gmul(s[c][2], 8'h09) ^ gmul(s[c][3], 8'h0e);
    end
    return o;
  endfunction

endpackage

// File: rtl/inv_cipher_if.sv
// Block-level handshake bundle for the inverse cipher: ciphertext/key in, plaintext out.
interface inv_cipher_if;
  import Cipher_defs::*;

  logic   in_valid;
  logic   in_ready;
  t_state ct;
  t_state key;
  logic   out_valid;
  logic   out_ready;
  t_state pt;

  modport master (
    output in_valid, ct, key, out_ready,
    input  in_ready, out_valid, pt
  );

  modport slave (
    input  in_valid, ct, key, out_ready,
    output in_ready, out_valid, pt
  );
endinterface

// File: rtl/round_key_step.sv
// One step of the AES-128 key schedule, forward (dir=0) or backward (dir=1),
// sharing a single SubWord(RotWord) path between the two directions.
module round_key_step
  import Cipher_defs::*;
(
  input  t_state rk_in,
  input  t_word  rcon,
  input  logic   dir,
  output t_state rk_out
);

  t_state back;
  t_state fwd;
  t_word  g;

  // Backward unwinds w3..w1 first so that the recovered w3 feeds the shared g-function.
  always_comb begin
    back    = rk_in;
    back[3] = rk_in[3] ^ rk_in[2];
    back[2] = rk_in[2] ^ rk_in[1];
    back[1] = rk_in[1] ^ rk_in[0];
    g       = sub_word(rot_word(dir ? back[3] : rk_in[3])) ^ rcon;
    back[0] = rk_in[0] ^ g;
    fwd[0]  = rk_in[0] ^ g;
    fwd[1]  = rk_in[1] ^ fwd[0];
    fwd[2]  = rk_in[2] ^ fwd[1];
    fwd[3]  = rk_in[3] ^ fwd[2];
    rk_out  = dir ? back : fwd;
  end

endmodule

// File: rtl/inv_cipher.sv
// Iterative AES-128 inverse cipher, one round per clock. The key schedule is
// run forward to round key 10, then unwound one step per round alongside the data.
module inv_cipher
  import Cipher_defs::*;
(
  input  logic        clk,
  input  logic        rst,
  inv_cipher_if.slave bus
);

  t_fsm       state_reg, state_next;
  t_state     st_reg, st_next;
  t_state     rk_reg, rk_next;
  t_state     ct_reg, ct_next;
  t_state     key0_reg, key0_next;
  logic [3:0] rnd_reg, rnd_next;
  logic       in_ready, out_valid;
  t_state     rk_step;
  logic [3:0] rc_idx;

  // The counter has run one past 10 when INIT unwinds the last key, so pin Rcon[10] there.
  assign rc_idx = (state_reg == INIT) ? 4'd10 : rnd_reg;

  round_key_step u_rks (
    .rk_in  (rk_reg),
    .rcon   ({RCON[rc_idx], 24'h0}),
    .dir    (state_reg != KEYEXP),
    .rk_out (rk_step)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      st_reg    <= '0;
      rk_reg    <= '0;
      ct_reg    <= '0;
      key0_reg  <= '0;
      rnd_reg   <= '0;
    end else begin
      state_reg <= state_next;
      st_reg    <= st_next;
      rk_reg    <= rk_next;
      ct_reg    <= ct_next;
      key0_reg  <= key0_next;
      rnd_reg   <= rnd_next;
    end
  end

  // Next-state, datapath updates and handshake outputs.
  always_comb begin
    state_next = state_reg;
    st_next    = st_reg;
    rk_next    = rk_reg;
    ct_next    = ct_reg;
    key0_next  = key0_reg;
    rnd_next   = rnd_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    unique case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          ct_next    = bus.ct;
          rk_next    = bus.key;
          key0_next  = bus.key;
          rnd_next   = 4'd1;
          state_next = KEYEXP;
        end
      end
      KEYEXP: begin
        rk_next  = rk_step;
        rnd_next = rnd_reg + 4'd1;
        if (rnd_reg == 4'd10) state_next = INIT;
      end
      INIT: begin
        st_next    = ct_reg ^ rk_reg;
        rk_next    = rk_step;
        rnd_next   = 4'd9;
        state_next = ROUND;
      end
      ROUND: begin
        st_next  = inv_mix_columns(inv_sub_bytes(inv_shift_rows(st_reg)) ^ rk_reg);
        rk_next  = rk_step;
        rnd_next = rnd_reg - 4'd1;
        if (rnd_reg == 4'd1) state_next = FINAL;
      end
      FINAL: begin
        st_next    = inv_sub_bytes(inv_shift_rows(st_reg)) ^ rk_reg;
        state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.pt        = st_reg;

  // The backward key schedule must land exactly on the cipher key for the last round.
  always_ff @(posedge clk) begin
    if (!rst && state_reg == FINAL) assert (rk_reg == key0_reg);
  end

endmodule

// File: tb/tb_inv_cipher.sv
// Directed and randomised checks of the AES-128 inverse cipher block.
module tb_inv_cipher;
  import Cipher_defs::*;

  localparam logic [127:0] K_C1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_C1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] RK10_B = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   t0 = 0;
  logic [7:0] tb_sbox [256];

  inv_cipher_if bus ();

  inv_cipher dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Independent reference: GF(2^8) arithmetic and S-box from inverse + affine map.
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xt(aa);
    end
    return p;
  endfunction

  function automatic logic [7:0] sb_calc(input logic [7:0] b);
    logic [7:0] inv, s;
    inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gm(inv, b);
    s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    return s;
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] p, input logic [127:0] k);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] w [16];
    logic [7:0] g [4];
    logic [7:0] rc, a0, a1, a2, a3;
    logic [127:0] res;
    rc = 8'h01;
    for (int i = 0; i < 16; i++) begin
      w[i] = k[127-8*i -: 8];
      s[i] = p[127-8*i -: 8] ^ w[i];
    end
    for (int rd = 1; rd <= 10; rd++) begin
      for (int j = 0; j < 4; j++) g[j] = tb_sbox[w[12 + ((j + 1) % 4)]];
      g[0] = g[0] ^ rc;
      rc = xt(rc);
      for (int j = 0; j < 4; j++) w[j] = w[j] ^ g[j];
      for (int j = 4; j < 16; j++) w[j] = w[j] ^ w[j-4];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          t[r+4*c] = tb_sbox[s[r + 4*((c + r) % 4)]];
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (rd < 10) begin
          t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
        for (int r = 0; r < 4; r++) s[4*c+r] = t[4*c+r] ^ w[4*c+r];
      end
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Present one block at a negedge; returns at the negedge after the accept edge.
  task automatic send(input logic [127:0] k, input logic [127:0] c, input logic hold);
    bus.key = k;
    bus.ct = c;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    t0 = cyc;
    if (hold) begin
      bus.ct = rand128();
      bus.key = rand128();
    end else begin
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic wait_valid(output int lat);
    lat = -1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) begin
        lat = cyc - t0;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int bad;
    logic [127:0] p0, k, p, c;

    for (int i = 0; i < 256; i++) tb_sbox[i] = sb_calc(8'(i));

    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.ct = '0;
    bus.key = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_pt", bus.pt, 0);
    check("rst_rnd", dut.rnd_reg, 0);

    // FIPS-197 C.1 with latency
    send(K_C1, CT_C1, 1'b0);
    check("c1_busy_ready", bus.in_ready, 0);
    wait_valid(lat);
    check("c1_latency", lat, 21);
    check("c1_pt", bus.pt, PT_C1);
    check("c1_done_ready", bus.in_ready, 0);
    @(negedge clk);
    check("c1_idle_ready", bus.in_ready, 1);
    check("c1_idle_valid", bus.out_valid, 0);
    $display("txn c1: pt=%h lat=%0d", PT_C1, lat);

    // FIPS-197 B with the round-10 key visible at INIT entry
    send(K_B, CT_B, 1'b0);
    repeat (10) @(negedge clk);
    check("b_init_state", dut.state_reg, INIT);
    check("b_init_rk", dut.rk_reg, RK10_B);
    wait_valid(lat);
    check("b_latency", lat, 21);
    check("b_pt", bus.pt, PT_B);
    @(negedge clk);
    $display("txn b: pt=%h lat=%0d", PT_B, lat);

    // Backpressure: hold the result for 50 cycles
    bus.out_ready = 1'b0;
    send(K_C1, CT_C1, 1'b0);
    wait_valid(lat);
    p0 = bus.pt;
    bad = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (bus.pt !== p0 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) bad++;
    end
    check("bp_pt", p0, PT_C1);
    check("bp_stable", bad, 0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", bus.in_ready, 1);
    check("bp_release_valid", bus.out_valid, 0);
    $display("txn backpressure: pt=%h held 50 cycles", p0);

    // Busy: in_valid pulses during KEYEXP and ROUND must be ignored
    send(K_C1, CT_C1, 1'b0);
    lat = -1;
    for (int n = 0; n < 100; n++) begin
      bus.in_valid = ((cyc - t0) == 3) || ((cyc - t0) == 14);
      bus.ct = CT_B;
      bus.key = K_B;
      @(negedge clk);
      if (bus.out_valid === 1'b1) begin
        lat = cyc - t0;
        break;
      end
    end
    bus.in_valid = 1'b0;
    check("busy_latency", lat, 21);
    check("busy_pt", bus.pt, PT_C1);
    @(negedge clk);
    $display("txn busy: pt=%h lat=%0d", PT_C1, lat);

    // Reset in the middle of ROUND
    send(K_C1, CT_C1, 1'b0);
    repeat (15) @(negedge clk);
    check("mid_rnd", dut.rnd_reg, 5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_out_valid", bus.out_valid, 0);
    check("mid_in_ready", bus.in_ready, 1);
    check("mid_pt", bus.pt, 0);
    send(K_C1, CT_C1, 1'b0);
    wait_valid(lat);
    check("after_rst_latency", lat, 21);
    check("after_rst_pt", bus.pt, PT_C1);
    @(negedge clk);
    $display("txn reset-recover: pt=%h lat=%0d", PT_C1, lat);

    // Random regression with continuous in_valid and out_ready
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      k = rand128();
      p = rand128();
      c = aes_enc(p, k);
      if (bus.in_ready !== 1'b1) bad++;
      send(k, c, 1'b1);
      wait_valid(lat);
      if (lat != 21) bad++;
      check("regress_pt", bus.pt, p);
      $display("txn rnd %0d: key=%h ct=%h pt=%h lat=%0d", i, k, c, bus.pt, lat);
      if (lat < 0) break;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    check("regress_timing", bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
